// File: rtl/cpu_pkg.sv
// Purpose: shared ISA and FSM definitions for the multi-cycle 16-bit CPU core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode-class and FSM state enums, SYS sub-codes, instruction field
// bit positions, and the index of the register that aliases the PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        CLS_SYS = 2'b00,
        CLS_SET = 2'b01,
        CLS_MEM = 2'b10,
        CLS_ALU = 2'b11
    } op_class_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // SYS sub-codes in ir[2:0]; 101..111 are no-ops.
    localparam logic [2:0] SYS_HALT  = 3'd0;
    localparam logic [2:0] SYS_SET_Z = 3'd1;
    localparam logic [2:0] SYS_CLR_Z = 3'd2;
    localparam logic [2:0] SYS_SET_C = 3'd3;
    localparam logic [2:0] SYS_CLR_C = 3'd4;

    // Instruction field positions.
    localparam int ClsHi   = 15;
    localparam int ClsLo   = 14;
    localparam int RdHi    = 13;
    localparam int RdLo    = 11;
    localparam int RaHi    = 10;
    localparam int RaLo    = 8;
    localparam int RbHi    = 7;
    localparam int RbLo    = 5;
    localparam int ImmHi   = 10;
    localparam int LoadBit = 7;
    localparam int OffHi   = 6;
    localparam int SysHi   = 2;
    localparam int AluOpHi = 4;

    // r7 is not stored; it reads and writes the program counter.
    localparam logic [2:0] PcReg = 3'd7;

endpackage

// File: rtl/cpu_regfile.sv
// Purpose: 8-entry register file with r7 aliased onto the program counter.
// Latency: reads are combinational; writes and PC updates land on the next clk edge.
// Backpressure: none; the core only asserts wr_en/retire when an instruction commits.
// Ports: two read ports (rd_a/rd_b), one write port, a debug read port,
// retire (advance PC by one) and pc_o (current PC).
module cpu_regfile import cpu_pkg::*; #(
    parameter int          DataWidth = 16,
    parameter int          AddrWidth = 16,
    parameter int unsigned ResetPc   = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [2:0]           rd_a_addr,
    output logic [DataWidth-1:0] rd_a_dat,
    input  logic [2:0]           rd_b_addr,
    output logic [DataWidth-1:0] rd_b_dat,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [DataWidth-1:0] wr_dat,
    input  logic                 retire,
    input  logic [2:0]           dbg_addr,
    output logic [DataWidth-1:0] dbg_dat,
    output logic [AddrWidth-1:0] pc_o
);

    // Entry 7 of the array is never written; reads of r7 are steered to pc_q.
    logic [DataWidth-1:0] regs_q [8];
    logic [DataWidth-1:0] regs_d [8];
    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] pc_d;
    logic                 pc_wr;

    assign pc_wr = wr_en && (wr_addr == PcReg);

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !pc_wr) begin
            regs_d[wr_addr] = wr_dat;
        end
        // A write to r7 redirects the next fetch and suppresses the increment.
        pc_d = pc_q;
        if (pc_wr) begin
            pc_d = wr_dat[AddrWidth-1:0];
        end else if (retire) begin
            pc_d = pc_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            pc_q <= AddrWidth'(ResetPc);
        end else begin
            regs_q <= regs_d;
            pc_q   <= pc_d;
        end
    end

    assign rd_a_dat = (rd_a_addr == PcReg) ? DataWidth'(pc_q) : regs_q[rd_a_addr];
    assign rd_b_dat = (rd_b_addr == PcReg) ? DataWidth'(pc_q) : regs_q[rd_b_addr];
    assign dbg_dat  = (dbg_addr  == PcReg) ? DataWidth'(pc_q) : regs_q[dbg_addr];
    assign pc_o     = pc_q;

endmodule

// File: rtl/cpu_core.sv
// Purpose: multi-cycle fetch/execute/memory core for the 16-bit SYS/SET/MEM/ALU ISA.
// Latency: SYS/SET/ALU 2 cycles, MEM 3 cycles with zero-wait memories; +1 per wait cycle.
// Backpressure: fetch waits for imemValid, MEM waits for dmemAck with request fields held stable.
// Ports: run/step debug control, instruction and data memory handshakes,
// external ALU operand/result ports, flags, halted, retire pulse, pc, debug register read.
module cpu_core import cpu_pkg::*; #(
    parameter int          DataWidth = 16,   // >= 16
    parameter int          AddrWidth = 16,   // <= DataWidth
    parameter int unsigned ResetPc   = 0
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 runEn,
    input  logic                 stepReq,
    output logic                 imemReq,
    output logic [AddrWidth-1:0] imemAddr,
    input  logic                 imemValid,
    input  logic [15:0]          imemData,
    output logic                 dmemReq,
    output logic                 dmemWe,
    output logic [AddrWidth-1:0] dmemAddr,
    output logic [DataWidth-1:0] dmemWdata,
    input  logic                 dmemAck,
    input  logic [DataWidth-1:0] dmemRdata,
    output logic [DataWidth-1:0] aluA,
    output logic [DataWidth-1:0] aluB,
    output logic [4:0]           aluOp,
    output logic                 aluEnable,
    input  logic [DataWidth:0]   aluOut,
    input  logic                 aluZero,
    input  logic                 aluCarry,
    input  logic                 aluCondMet,
    output logic                 zeroFlag,
    output logic                 carryFlag,
    output logic                 halted,
    output logic                 retire,
    output logic [AddrWidth-1:0] pc,
    input  logic [2:0]           dbgAddr,
    output logic [DataWidth-1:0] dbgData
);

    state_e               state_q, state_d;
    logic [15:0]          ir_q, ir_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 step_q, step_d;

    op_class_e            cls;
    logic                 fetch_go;
    logic                 fetch_done;
    logic                 retire_c;
    logic                 alu_en;
    logic                 wr_en;
    logic [DataWidth-1:0] wr_dat;
    logic [2:0]           rd_b_addr;
    logic [DataWidth-1:0] rd_a_dat;
    logic [DataWidth-1:0] rd_b_dat;

    // Carry arrives separately on aluCarry; the result MSB is not needed.
    logic                 unused_alu_msb;
    assign unused_alu_msb = aluOut[DataWidth];

    assign cls        = op_class_e'(ir_q[ClsHi:ClsLo]);
    assign fetch_go   = (state_q == ST_FETCH) && (runEn || step_q);
    assign fetch_done = fetch_go && imemValid;

    // Port B reads the store source in MEM and the second ALU operand otherwise.
    assign rd_b_addr = (state_q == ST_MEM) ? ir_q[RdHi:RdLo] : ir_q[RbHi:RbLo];

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        step_d   = step_q;
        retire_c = 1'b0;
        alu_en   = 1'b0;
        wr_en    = 1'b0;
        wr_dat   = '0;

        // A step landing in the same cycle as a completing fetch is kept for the next one.
        if (fetch_done) begin
            step_d = 1'b0;
        end
        if (stepReq && !runEn && (state_q != ST_HALT)) begin
            step_d = 1'b1;
        end

        case (state_q)
            ST_FETCH: begin
                if (fetch_done) begin
                    ir_d    = imemData;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d  = ST_FETCH;
                retire_c = 1'b1;
                case (cls)
                    CLS_SYS: begin
                        case (ir_q[SysHi:0])
                            SYS_HALT:  state_d = ST_HALT;
                            SYS_SET_Z: zero_d  = 1'b1;
                            SYS_CLR_Z: zero_d  = 1'b0;
                            SYS_SET_C: carry_d = 1'b1;
                            SYS_CLR_C: carry_d = 1'b0;
                            default:   ;
                        endcase
                    end
                    CLS_SET: begin
                        wr_en  = 1'b1;
                        wr_dat = DataWidth'(ir_q[ImmHi:0]);
                    end
                    CLS_ALU: begin
                        alu_en = 1'b1;
                        if (aluCondMet) begin
                            wr_en   = 1'b1;
                            wr_dat  = aluOut[DataWidth-1:0];
                            zero_d  = aluZero;
                            carry_d = aluCarry;
                        end
                    end
                    CLS_MEM: begin
                        retire_c = 1'b0;
                        state_d  = ST_MEM;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (dmemAck) begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                    if (ir_q[LoadBit]) begin
                        wr_en  = 1'b1;
                        wr_dat = dmemRdata;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            step_q  <= step_d;
        end
    end

    cpu_regfile #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth),
        .ResetPc   (ResetPc)
    ) u_regfile (
        .clk       (clk),
        .rstN      (rstN),
        .rd_a_addr (ir_q[RaHi:RaLo]),
        .rd_a_dat  (rd_a_dat),
        .rd_b_addr (rd_b_addr),
        .rd_b_dat  (rd_b_dat),
        .wr_en     (wr_en),
        .wr_addr   (ir_q[RdHi:RdLo]),
        .wr_dat    (wr_dat),
        .retire    (retire_c),
        .dbg_addr  (dbgAddr),
        .dbg_dat   (dbgData),
        .pc_o      (pc)
    );

    // FETCH is the reset state, so the fetch request is also masked by rstN
    // to keep it low while reset is held.
    assign imemReq   = rstN && fetch_go;
    assign imemAddr  = pc;
    assign dmemReq   = rstN && (state_q == ST_MEM);
    assign dmemWe    = dmemReq && !ir_q[LoadBit];
    assign dmemAddr  = rd_a_dat[AddrWidth-1:0] + AddrWidth'(ir_q[OffHi:0]);
    assign dmemWdata = rd_b_dat;
    assign aluA      = rd_a_dat;
    assign aluB      = rd_b_dat;
    assign aluOp     = ir_q[AluOpHi:0];
    assign aluEnable = alu_en;
    assign zeroFlag  = zero_q;
    assign carryFlag = carry_q;
    assign halted    = (state_q == ST_HALT);
    assign retire    = retire_c;

endmodule
